bullet_pool: RTL and testbench

Fixed-capacity pool of player bullets, sitting directly downstream of the speed-control stage. It consumes the toggling `bullet_update_i` rate signal and treats every toggle as one move tick. It spawns bullets at the player position on a fire-button press and moves every live bullet upward one step per tick. It also answers a registered per-pixel "bullet here" query for the VGA renderer.

---
 rtl/bullet_pkg.sv | 25 ++
 rtl/bullet_pool_edge_detect.sv | 34 +++
 rtl/bullet_pool.sv | 194 +++++++++++++++++++
 tb/tb_bullet_pool.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// ---------------------------------------------------------------------------
// bullet_pkg
// Shared types and default constants for the player bullet pool.
//   coord_t   : one screen coordinate at the default width
//   bullet_t  : one pool slot {active, x, y}
//   DEF_*     : default geometry and motion constants used as parameter
//               defaults by bullet_pool
// ---------------------------------------------------------------------------
package bullet_pkg;

    localparam int DEF_COORD_W        = 10;
    localparam int DEF_BULLET_STEP    = 4;
    localparam int DEF_BULLET_W       = 2;
    localparam int DEF_BULLET_H       = 6;
    localparam int DEF_COOLDOWN_TICKS = 8;

    typedef logic [DEF_COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   active;
        coord_t x;
        coord_t y;
    } bullet_t;

endpackage

// File: rtl/bullet_pool_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Registers a level and reports its single-cycle rise, fall and toggle
// pulses relative to the previous clock.
//   clk_i    : system clock
//   rst_ni   : synchronous active-low reset; pulses are held low while
//              asserted
//   level_i  : level to watch
//   rise_o   : level went 0 -> 1
//   fall_o   : level went 1 -> 0
//   toggle_o : level changed in either direction
// ---------------------------------------------------------------------------
module edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o
);

    logic level_q;

    // The register simply tracks the input, reset included: loading the live
    // level during reset means nothing looks like an edge once reset drops.
    always_ff @(posedge clk_i) begin
        level_q <= level_i;
    end

    assign rise_o   = rst_ni &  level_i & ~level_q;
    assign fall_o   = rst_ni & ~level_i &  level_q;
    assign toggle_o = rst_ni & (level_i ^ level_q);

endmodule

// File: rtl/bullet_pool.sv
// ---------------------------------------------------------------------------
// bullet_pool
// Fixed pool of player bullets. Every toggle of bullet_update_i moves live
// bullets up by BULLET_STEP (expiring them near the top row), each fire
// press spawns a bullet at the player position in the lowest free slot, and
// a registered per-pixel hit flag is produced for the renderer.
//
// Optional feature: define BULLET_POOL_COOLDOWN_EN to enforce at least
// COOLDOWN_TICKS move ticks between spawns.
//
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   bullet_update_i      : toggle-rate move signal (each transition = tick)
//   fire_i               : fire button level
//   player_x_i/_y_i      : spawn position
//   pixel_x_i/_y_i       : renderer pixel being queried
//   bullet_pixel_o       : registered hit flag for last cycle's pixel
//   active_o             : per-slot live flags
//   count_o              : number of live slots
//   fire_ack_o           : pulse, a bullet was spawned
//   fire_drop_o          : pulse, a fire press was rejected
// ---------------------------------------------------------------------------
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int MAX_BULLETS    = 4,
    parameter int COORD_W        = DEF_COORD_W,
    parameter int BULLET_STEP    = DEF_BULLET_STEP,
    parameter int BULLET_W       = DEF_BULLET_W,
    parameter int BULLET_H       = DEF_BULLET_H,
    parameter int Y_TOP          = 0,
    parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               bullet_update_i,
    input  logic                               fire_i,
    input  logic [COORD_W-1:0]                 player_x_i,
    input  logic [COORD_W-1:0]                 player_y_i,
    input  logic [COORD_W-1:0]                 pixel_x_i,
    input  logic [COORD_W-1:0]                 pixel_y_i,
    output logic                               bullet_pixel_o,
    output logic [MAX_BULLETS-1:0]             active_o,
    output logic [$clog2(MAX_BULLETS+1)-1:0]   count_o,
    output logic                               fire_ack_o,
    output logic                               fire_drop_o
);

    localparam int CNT_W = $clog2(MAX_BULLETS + 1);
    localparam int IDX_W = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;

    // Widened constants so comparisons and box edges never wrap.
    localparam logic [COORD_W:0] EXPIRE_LIM = (COORD_W+1)'(Y_TOP + BULLET_STEP);
    localparam logic [COORD_W:0] BOX_W      = (COORD_W+1)'(BULLET_W);
    localparam logic [COORD_W:0] BOX_H      = (COORD_W+1)'(BULLET_H);

    logic [MAX_BULLETS-1:0] active_q, active_d;
    logic [COORD_W-1:0]     x_q [MAX_BULLETS];
    logic [COORD_W-1:0]     y_q [MAX_BULLETS];
    logic [COORD_W-1:0]     x_d [MAX_BULLETS];
    logic [COORD_W-1:0]     y_d [MAX_BULLETS];

    logic             tick, fire_ev, spawn, cd_ready, have_free, hit;
    logic [IDX_W-1:0] free_idx;
    logic             upd_rise_unused, upd_fall_unused;
    logic             fire_fall_unused, fire_toggle_unused;

    edge_detect u_upd_edge (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .level_i  (bullet_update_i),
        .rise_o   (upd_rise_unused),
        .fall_o   (upd_fall_unused),
        .toggle_o (tick)
    );

    edge_detect u_fire_edge (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .level_i  (fire_i),
        .rise_o   (fire_ev),
        .fall_o   (fire_fall_unused),
        .toggle_o (fire_toggle_unused)
    );

`ifdef BULLET_POOL_COOLDOWN_EN
    localparam int CD_W = ($clog2(COOLDOWN_TICKS + 1) > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    logic [CD_W-1:0] cd_q;

    assign cd_ready = (cd_q == '0);

    // Reloaded on every spawn; otherwise counts ticks down to zero and stays.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cd_q <= '0;
        end else if (spawn) begin
            cd_q <= CD_W'(COOLDOWN_TICKS);
        end else if (tick && !cd_ready) begin
            cd_q <= cd_q - 1'b1;
        end
    end
`else
    // Without the cooldown every press is eligible.
    assign cd_ready = (COOLDOWN_TICKS >= 0);
`endif

    // Lowest free slot, judged on the registered flags so that a slot
    // expiring in this very cycle is not handed out until the next one.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    assign spawn = fire_ev & have_free & cd_ready;

    // Move or expire first, then place the new bullet at the unmoved spawn
    // position.
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            if (tick && active_q[i]) begin
                if ({1'b0, y_q[i]} < EXPIRE_LIM) begin
                    active_d[i] = 1'b0;
                    x_d[i]      = '0;
                    y_d[i]      = '0;
                end else begin
                    y_d[i] = y_q[i] - COORD_W'(BULLET_STEP);
                end
            end
            if (spawn && (free_idx == IDX_W'(i))) begin
                active_d[i] = 1'b1;
                x_d[i]      = player_x_i;
                y_d[i]      = player_y_i;
            end
        end
    end

    // Box test against the registered slots, done one bit wider than a
    // coordinate so boxes at the screen edge do not wrap.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            if (active_q[i] &&
                ({1'b0, pixel_x_i} >= {1'b0, x_q[i]}) &&
                ({1'b0, pixel_x_i} <  ({1'b0, x_q[i]} + BOX_W)) &&
                ({1'b0, pixel_y_i} >= {1'b0, y_q[i]}) &&
                ({1'b0, pixel_y_i} <  ({1'b0, y_q[i]} + BOX_H))) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            count_o = count_o + CNT_W'(active_q[i]);
        end
    end

    // Slot storage and the registered pulses / pixel flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q       <= '0;
            bullet_pixel_o <= 1'b0;
            fire_ack_o     <= 1'b0;
            fire_drop_o    <= 1'b0;
            for (int i = 0; i < MAX_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            active_q       <= active_d;
            bullet_pixel_o <= hit;
            fire_ack_o     <= spawn;
            fire_drop_o    <= fire_ev & ~spawn;
            for (int i = 0; i < MAX_BULLETS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: tb/tb_bullet_pool.sv
// ---------------------------------------------------------------------------
// tb_bullet_pool
// Self-checking bench for bullet_pool with default parameters. A small
// slot-level reference model predicts every output each cycle; a handful of
// fixed-value checks pin down the documented scenarios. Honours
// BULLET_POOL_COOLDOWN_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bullet_pool;

    localparam int NB   = 4;
    localparam int STEP = 4;
    localparam int BW   = 2;
    localparam int BH   = 6;
    localparam int CD   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       upd = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] player_x = '0, player_y = '0, pixel_x = '0, pixel_y = '0;
    logic       bullet_pixel, fire_ack, fire_drop;
    logic [3:0] active;
    logic [2:0] count;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: slot contents plus last sampled inputs.
    int   m_act [NB];
    int   m_x   [NB];
    int   m_y   [NB];
    int   m_cd = 0;
    logic m_upd_prev = 1'b0, m_fire_prev = 1'b0;
    int   e_pix = 0, e_ack = 0, e_drop = 0;

    bullet_pool dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .bullet_update_i (upd),
        .fire_i          (fire),
        .player_x_i      (player_x),
        .player_y_i      (player_y),
        .pixel_x_i       (pixel_x),
        .pixel_y_i       (pixel_y),
        .bullet_pixel_o  (bullet_pixel),
        .active_o        (active),
        .count_o         (count),
        .fire_ack_o      (fire_ack),
        .fire_drop_o     (fire_drop)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        else
            passCount++;
    endtask

    // Advance the model by one clock edge using the inputs now being driven.
    task automatic modelStep();
        int  px, py, plx, ply, freeSlot;
        bit  tick, fev, ok;
        px  = int'(pixel_x);
        py  = int'(pixel_y);
        plx = int'(player_x);
        ply = int'(player_y);
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_cd = 0; e_pix = 0; e_ack = 0; e_drop = 0;
        end else begin
            tick = (upd != m_upd_prev);
            fev  = fire && !m_fire_prev;
            e_pix = 0;
            for (int i = 0; i < NB; i++)
                if (m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + BW &&
                    py >= m_y[i] && py < m_y[i] + BH)
                    e_pix = 1;
            freeSlot = -1;
            for (int i = 0; i < NB; i++)
                if (m_act[i] == 0 && freeSlot < 0) freeSlot = i;
            ok = fev && (freeSlot >= 0);
`ifdef BULLET_POOL_COOLDOWN_EN
            ok = ok && (m_cd == 0);
            if (ok) m_cd = CD;
            else if (tick && m_cd > 0) m_cd = m_cd - 1;
`endif
            if (tick)
                for (int i = 0; i < NB; i++)
                    if (m_act[i] != 0) begin
                        if (m_y[i] < STEP) m_act[i] = 0;
                        else m_y[i] = m_y[i] - STEP;
                    end
            if (ok) begin
                m_act[freeSlot] = 1;
                m_x[freeSlot]   = plx;
                m_y[freeSlot]   = ply;
            end
            e_ack  = ok ? 1 : 0;
            e_drop = (fev && !ok) ? 1 : 0;
        end
        m_upd_prev  = upd;
        m_fire_prev = fire;
    endtask

    task automatic checkAll();
        logic [3:0] ea;
        int ec;
        ea = '0;
        ec = 0;
        for (int i = 0; i < NB; i++) begin
            ea[i] = (m_act[i] != 0);
            ec += (m_act[i] != 0) ? 1 : 0;
        end
        checkOutput("active", 32'(active), 32'(ea));
        checkOutput("count", 32'(count), 32'(ec));
        checkOutput("ack", 32'(fire_ack), 32'(e_ack));
        checkOutput("drop", 32'(fire_drop), 32'(e_drop));
        checkOutput("pixel", 32'(bullet_pixel), 32'(e_pix));
    endtask

    // Drive one cycle at the falling edge, predict it, then compare after the
    // rising edge has taken effect (back at the next falling edge).
    task automatic applyStimulus(input logic r, input logic u, input logic f,
                                 input int plX, input int plY, input int pX, input int pY);
        rst_n    = r;
        upd      = u;
        fire     = f;
        player_x = plX[9:0];
        player_y = plY[9:0];
        pixel_x  = pX[9:0];
        pixel_y  = pY[9:0];
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    initial begin
        int plX, plY, pX, pY, k;
        logic r, u, f;
        @(negedge clk);

        // Reset, first spawn and motion.
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("reset_active", 32'(active), 32'd0);
        applyStimulus(1, upd, 1, 100, 400, 0, 0);
        checkOutput("first_ack", 32'(fire_ack), 32'd1);
        checkOutput("first_active", 32'(active), 32'b0001);
        checkOutput("first_count", 32'(count), 32'd1);
        applyStimulus(1, upd, 0, 100, 400, 0, 0);
        checkOutput("ack_one_cycle", 32'(fire_ack), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, ~upd, 0, 0, 0, 0, 0);
        applyStimulus(1, upd, 0, 0, 0, 101, 390);
        checkOutput("hit_101_390", 32'(bullet_pixel), 32'd1);
        applyStimulus(1, upd, 0, 0, 0, 102, 390);
        checkOutput("miss_102_390", 32'(bullet_pixel), 32'd0);

        // Expiry near the top without underflow.
        applyStimulus(0, upd, 0, 0, 0, 0, 0);
        applyStimulus(1, upd, 1, 50, 5, 0, 0);
        applyStimulus(1, upd, 0, 50, 5, 0, 0);
        applyStimulus(1, ~upd, 0, 0, 0, 0, 0);
        applyStimulus(1, upd, 0, 0, 0, 50, 1);
        checkOutput("hit_y1", 32'(bullet_pixel), 32'd1);
        applyStimulus(1, ~upd, 0, 0, 0, 0, 0);
        checkOutput("expired_count", 32'(count), 32'd0);

`ifndef BULLET_POOL_COOLDOWN_EN
        // Fill the pool, overflow, then same-cycle tick/expiry with fire.
        applyStimulus(0, upd, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            plY = (i == 2) ? 2 : 400;
            applyStimulus(1, upd, 1, 10 * (i + 1), plY, 0, 0);
            checkOutput("fill_ack", 32'(fire_ack), (i < 4) ? 32'd1 : 32'd0);
            checkOutput("fill_drop", 32'(fire_drop), (i < 4) ? 32'd0 : 32'd1);
            checkOutput("fill_count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
            applyStimulus(1, upd, 0, 0, 0, 0, 0);
        end
        applyStimulus(1, ~upd, 1, 300, 200, 0, 0);
        checkOutput("expire_fire_drop", 32'(fire_drop), 32'd1);
        checkOutput("expire_count", 32'(count), 32'd3);
        applyStimulus(1, upd, 0, 300, 200, 0, 0);
        applyStimulus(1, upd, 1, 300, 200, 0, 0);
        checkOutput("reuse_ack", 32'(fire_ack), 32'd1);
        checkOutput("reuse_active", 32'(active), 32'b1111);
        applyStimulus(1, upd, 0, 0, 0, 300, 200);
        checkOutput("reuse_pos", 32'(bullet_pixel), 32'd1);
`else
        // Cooldown window.
        applyStimulus(0, upd, 0, 0, 0, 0, 0);
        applyStimulus(1, upd, 1, 10, 600, 0, 0);
        checkOutput("cd_first_ack", 32'(fire_ack), 32'd1);
        applyStimulus(1, upd, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1, ~upd, 0, 0, 0, 0, 0);
        applyStimulus(1, upd, 1, 20, 600, 0, 0);
        checkOutput("cd_drop", 32'(fire_drop), 32'd1);
        applyStimulus(1, upd, 0, 0, 0, 0, 0);
        applyStimulus(1, ~upd, 0, 0, 0, 0, 0);
        applyStimulus(1, upd, 1, 30, 600, 0, 0);
        checkOutput("cd_ack", 32'(fire_ack), 32'd1);
        applyStimulus(1, upd, 0, 0, 0, 0, 0);
`endif

        // Reset in the middle of a tick and a press.
        applyStimulus(0, ~upd, 1, 5, 5, 0, 0);
        checkOutput("midreset_active", 32'(active), 32'd0);
        checkOutput("midreset_ack", 32'(fire_ack), 32'd0);
        applyStimulus(1, upd, 1, 5, 5, 0, 0);
        applyStimulus(1, upd, 0, 5, 5, 0, 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            r   = ($urandom_range(0, 59) != 0);
            u   = ($urandom_range(0, 2) == 0) ? ~upd : upd;
            f   = 1'($urandom_range(0, 1));
            plX = int'($urandom_range(0, 1023));
            plY = int'($urandom_range(0, 120));
            k   = int'($urandom_range(0, NB - 1));
            if (m_act[k] != 0) begin
                pX = m_x[k] + int'($urandom_range(0, 3)) - 1;
                pY = m_y[k] + int'($urandom_range(0, 7)) - 1;
            end else begin
                pX = int'($urandom_range(0, 1023));
                pY = int'($urandom_range(0, 127));
            end
            applyStimulus(r, u, f, plX, plY, pX, pY);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
